// File: rtl/ram_pipe.sv
// Dual-port req/ack RAM: read-only instruction port A, byte-lane read/write data port B,
// LATENCY-deep in-order ack pipeline. Optional macro RAM_PIPE_WR_FWD_EN: write-first on port A.
module ram_pipe #(
  parameter int    MEM_ADDR_WIDTH = 12,
  parameter int    LATENCY        = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr_addr,
  input  logic        i_instr_req,
  output logic [31:0] o_instr_data,
  output logic        o_instr_ack,
  output logic        o_instr_err,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wr_data,
  input  logic [1:0]  i_data_size,
  input  logic        i_data_we,
  input  logic        i_data_req,
  output logic [31:0] o_data_rd_data,
  output logic        o_data_ack,
  output logic        o_data_err
);

  localparam int IW    = MEM_ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IW;
  localparam int LAT   = (LATENCY < 1) ? 1 : (LATENCY > 4) ? 4 : LATENCY;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("ram_pipe: LATENCY must be in 1..4");
  end

  logic [31:0] mem [WORDS];

  logic [IW-1:0] i_idx;
  logic [IW-1:0] d_idx;
  logic          i_err;
  logic          d_err;
  logic          d_wr;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   i_word;
  logic [31:0]   d_word;
  logic [31:0]   i_rd;
  logic [31:0]   d_rd;

  assign i_idx  = i_instr_addr[MEM_ADDR_WIDTH-1:2];
  assign d_idx  = i_data_addr[MEM_ADDR_WIDTH-1:2];
  assign i_word = mem[i_idx];
  assign d_word = mem[d_idx];
  assign i_err  = (|i_instr_addr[31:MEM_ADDR_WIDTH]) | (|i_instr_addr[1:0]);
  assign d_wr   = i_data_req & i_data_we & ~d_err;

  always_comb begin
    d_err = |i_data_addr[31:MEM_ADDR_WIDTH];
    case (i_data_size)
      2'd0:    d_err = d_err;
      2'd1:    d_err = d_err | i_data_addr[0];
      2'd2:    d_err = d_err | (|i_data_addr[1:0]);
      default: d_err = 1'b1;
    endcase
  end

  // Source data is replicated across lanes so the lane mask alone positions it.
  always_comb begin
    case (i_data_size)
      2'd0: begin
        be = 4'b0001 << i_data_addr[1:0];
        wd = {4{i_data_wr_data[7:0]}};
      end
      2'd1: begin
        be = i_data_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{i_data_wr_data[15:0]}};
      end
      default: begin
        be = '1;
        wd = i_data_wr_data;
      end
    endcase
  end

  always_comb begin
    d_rd = d_word >> {i_data_addr[1:0], 3'b000};
    case (i_data_size)
      2'd0:    d_rd = d_rd & 32'h0000_00ff;
      2'd1:    d_rd = d_rd & 32'h0000_ffff;
      default: d_rd = d_word;
    endcase
  end

`ifdef RAM_PIPE_WR_FWD_EN
  always_comb begin
    i_rd = i_word;
    if (d_wr && (d_idx == i_idx)) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) i_rd[8*k +: 8] = wd[8*k +: 8];
      end
    end
  end
`else
  assign i_rd = i_word;
`endif

  always_ff @(posedge i_clk) begin
    if (d_wr) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) mem[d_idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  logic        i_ack_q [LAT];
  logic        i_err_q [LAT];
  logic [31:0] i_dat_q [LAT];
  logic        d_ack_q [LAT];
  logic        d_err_q [LAT];
  logic [31:0] d_dat_q [LAT];

  // Stage 0 captures the response at the accepting edge; later stages only delay it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        i_ack_q[k] <= 1'b0;
        i_err_q[k] <= 1'b0;
        i_dat_q[k] <= '0;
        d_ack_q[k] <= 1'b0;
        d_err_q[k] <= 1'b0;
        d_dat_q[k] <= '0;
      end
    end else begin
      i_ack_q[0] <= i_instr_req;
      i_err_q[0] <= i_instr_req & i_err;
      i_dat_q[0] <= (i_instr_req & ~i_err) ? i_rd : '0;
      d_ack_q[0] <= i_data_req;
      d_err_q[0] <= i_data_req & d_err;
      d_dat_q[0] <= (i_data_req & ~d_err & ~i_data_we) ? d_rd : '0;
      for (int unsigned k = 1; k < LAT; k++) begin
        i_ack_q[k] <= i_ack_q[k-1];
        i_err_q[k] <= i_err_q[k-1];
        i_dat_q[k] <= i_dat_q[k-1];
        d_ack_q[k] <= d_ack_q[k-1];
        d_err_q[k] <= d_err_q[k-1];
        d_dat_q[k] <= d_dat_q[k-1];
      end
    end
  end

  assign o_instr_ack    = i_ack_q[LAT-1];
  assign o_instr_err    = i_err_q[LAT-1];
  assign o_instr_data   = i_dat_q[LAT-1];
  assign o_data_ack     = d_ack_q[LAT-1];
  assign o_data_err     = d_err_q[LAT-1];
  assign o_data_rd_data = d_dat_q[LAT-1];

endmodule

// File: tb/tb_ram_pipe.sv
// Bench for ram_pipe: LATENCY=1 and LATENCY=3 instances share stimulus; a due-cycle scoreboard
// checks every ack. Honours RAM_PIPE_WR_FWD_EN for the same-cycle collision expectations.
module tb_ram_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ia = '0;
  logic        ireq = 1'b0;
  logic [31:0] da = '0;
  logic [31:0] dwd = '0;
  logic [1:0]  dsz = '0;
  logic        dwe = 1'b0;
  logic        dreq = 1'b0;

  logic [31:0] i1_data, d1_data, i3_data, d3_data;
  logic        i1_ack, i1_err, d1_ack, d1_err;
  logic        i3_ack, i3_err, d3_ack, d3_err;

  always #5 clk = ~clk;

  ram_pipe #(.MEM_ADDR_WIDTH(12), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst),
    .i_instr_addr(ia), .i_instr_req(ireq),
    .o_instr_data(i1_data), .o_instr_ack(i1_ack), .o_instr_err(i1_err),
    .i_data_addr(da), .i_data_wr_data(dwd), .i_data_size(dsz), .i_data_we(dwe), .i_data_req(dreq),
    .o_data_rd_data(d1_data), .o_data_ack(d1_ack), .o_data_err(d1_err)
  );

  ram_pipe #(.MEM_ADDR_WIDTH(12), .LATENCY(3)) u_l3 (
    .i_clk(clk), .i_rst(rst),
    .i_instr_addr(ia), .i_instr_req(ireq),
    .o_instr_data(i3_data), .o_instr_ack(i3_ack), .o_instr_err(i3_err),
    .i_data_addr(da), .i_data_wr_data(dwd), .i_data_size(dsz), .i_data_we(dwe), .i_data_req(dreq),
    .o_data_rd_data(d3_data), .o_data_ack(d3_ack), .o_data_err(d3_err)
  );

`ifdef RAM_PIPE_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        dq;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] da;
    logic [31:0] wd;
    logic        de;
    logic [31:0] dx;
    logic        iq;
    logic [31:0] ia;
    logic        ie;
    logic [31:0] ix;
  } vec_t;

  typedef struct {
    int          id;
    int          due;
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t v(input logic dq, input logic we, input logic [1:0] sz,
                             input logic [31:0] dad, input logic [31:0] wd,
                             input logic de, input logic [31:0] dx,
                             input logic iq, input logic [31:0] iad,
                             input logic ie, input logic [31:0] ix);
    vec_t r;
    r.dq = dq; r.we = we; r.sz = sz; r.da = dad; r.wd = wd; r.de = de; r.dx = dx;
    r.iq = iq; r.ia = iad; r.ie = ie; r.ix = ix;
    return r;
  endfunction

  task automatic get_out(input int id, output logic a, output logic e, output logic [31:0] d);
    case (id)
      0: begin a = i1_ack; e = i1_err; d = i1_data; end
      1: begin a = d1_ack; e = d1_err; d = d1_data; end
      2: begin a = i3_ack; e = i3_err; d = i3_data; end
      default: begin a = d3_ack; e = d3_err; d = d3_data; end
    endcase
  endtask

  task automatic check_outputs();
    for (int id = 0; id < 4; id++) begin
      logic a, e;
      logic [31:0] d;
      int hit;
      get_out(id, a, e, d);
      hit = -1;
      foreach (sb[i]) if (sb[i].id == id && sb[i].due == cyc) hit = i;
      checks++;
      if (hit >= 0) begin
        if (a !== 1'b1 || e !== sb[hit].err || d !== sb[hit].data) begin
          failures++;
          $display("FAIL %s cyc=%0d: got ack=%b err=%b data=%h, want ack=1 err=%b data=%h",
                   sb[hit].name, cyc, a, e, d, sb[hit].err, sb[hit].data);
        end
        sb.delete(hit);
      end else if (a !== 1'b0) begin
        failures++;
        $display("FAIL unexpected_ack port%0d cyc=%0d: got ack=%b, want ack=0", id, cyc, a);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int id = 0; id < 4; id++) begin
      logic a, e;
      logic [31:0] d;
      get_out(id, a, e, d);
      checks++;
      if (a !== 1'b0 || e !== 1'b0 || d !== 32'h0) begin
        failures++;
        $display("FAIL %s port%0d: got ack=%b err=%b data=%h, want all 0", tag, id, a, e, d);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic push(input int port, input logic err, input logic [31:0] data, input string what);
    for (int n = 0; n < 2; n++) begin
      exp_t x;
      x.id   = n * 2 + port;
      x.due  = cyc + (n == 0 ? 1 : 3);
      x.err  = err;
      x.data = data;
      x.name = $sformatf("L%0d_%s_%s", (n == 0 ? 1 : 3), (port == 0 ? "instr" : "data"), what);
      sb.push_back(x);
    end
  endtask

  task automatic apply(input vec_t t, input string what);
    dreq = t.dq; dwe = t.we; dsz = t.sz; da = t.da; dwd = t.wd;
    ireq = t.iq; ia = t.ia;
    if (t.iq) push(0, t.ie, t.ix, what);
    if (t.dq) push(1, t.de, t.dx, what);
    tick();
    dreq = 1'b0; dwe = 1'b0; ireq = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // data: req we size addr wdata err exp | instr: req addr err exp
    vecs.push_back(v(1, 1, 2, 32'h010, 32'hDEADBEEF, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 0, 2, 32'h010, 0,            0, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 2, 32'h010, 32'h11223344, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 32'h013, 32'h555555AA, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 0, 2, 32'h010, 0,            0, 32'hAA223344, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 32'h012, 0,            0, 32'h0000AA22, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 32'h011, 0,            0, 32'h00000033, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 1, 32'h016, 32'hFFFFBEEF, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 32'h016, 0,            0, 32'h0000BEEF, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 32'h017, 0,            0, 32'h000000BE, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 2, 32'h002, 0,            1, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 0, 3, 32'h010, 0,            1, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 0, 2, 32'h1000, 0,           1, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 1, 2, 32'h1010, 0,           1, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 1, 3, 32'h010, 0,            1, 0,            1, 32'h006, 1, 0));
    vecs.push_back(v(1, 1, 1, 32'h011, 0,            1, 0,            1, 32'h010, 0, 32'hAA223344));
    vecs.push_back(v(1, 0, 2, 32'h010, 0,            0, 32'hAA223344, 1, 32'h1010, 1, 0));
    vecs.push_back(v(1, 1, 2, 32'h020, 0,            0, 0,            1, 32'h002, 1, 0));
    vecs.push_back(v(1, 1, 2, 32'h020, 32'h12345678, 0, 0,            1, 32'h020, 0,
                     FWD ? 32'h12345678 : 32'h0));
    vecs.push_back(v(1, 0, 2, 32'h020, 0,            0, 32'h12345678, 1, 32'h020, 0, 32'h12345678));
    vecs.push_back(v(1, 1, 0, 32'h021, 32'h00000099, 0, 0,            1, 32'h020, 0,
                     FWD ? 32'h12349978 : 32'h12345678));
    vecs.push_back(v(1, 1, 2, 32'h000, 32'h000000A0, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 1, 2, 32'h004, 32'h000000A4, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 1, 2, 32'h008, 32'h000000A8, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 1, 2, 32'h00C, 32'h000000AC, 0, 0,            0, 0, 0, 0));
    vecs.push_back(v(1, 0, 2, 32'h000, 0,            0, 32'h000000A0, 1, 32'h000, 0, 32'h000000A0));
    vecs.push_back(v(1, 0, 2, 32'h004, 0,            0, 32'h000000A4, 1, 32'h004, 0, 32'h000000A4));
    vecs.push_back(v(1, 0, 2, 32'h008, 0,            0, 32'h000000A8, 1, 32'h008, 0, 32'h000000A8));
    vecs.push_back(v(1, 0, 2, 32'h00C, 0,            0, 32'h000000AC, 1, 32'h00C, 0, 32'h000000AC));
    vecs.push_back(v(1, 0, 0, 32'h016, 0,            0, 32'h000000EF, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 2, 32'h020, 0,            0, FWD ? 32'h12349978 : 32'h12349978,
                     1, 32'h020, 0, 32'h12349978));

    #2 rst = 1'b1;
    #1 check_zero("reset_state");
    tick();
    rst = 1'b0;
    idle(2);

    foreach (vecs[n]) apply(vecs[n], $sformatf("vec%0d", n));
    idle(4);

    // Reset one cycle after a read: LATENCY=1 ack is already out, LATENCY=3 ack must vanish.
    apply(v(1, 1, 2, 32'h030, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0), "pre_reset_write");
    idle(4);
    apply(v(1, 0, 2, 32'h030, 0, 0, 32'hCAFEF00D, 1, 32'h030, 0, 32'hCAFEF00D), "inflight_read");
    rst = 1'b1;
    #1 check_zero("async_reset_clear");
    for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].due > cyc) sb.delete(k);
    idle(2);
    rst = 1'b0;
    idle(5);
    check_zero("post_reset_quiet");
    apply(v(1, 0, 2, 32'h030, 0, 0, 32'hCAFEF00D, 1, 32'h030, 0, 32'hCAFEF00D), "post_reset_read");
    idle(4);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
